// File: rtl/reg_port_arbiter_pkg.sv
// Shared definitions for the register-port arbiter: data widths, requester IDs
// and the access sequencer state encoding.
package reg_port_arbiter_pkg;

    localparam int REG_W = 16;
    localparam int SEL_W = 3;

    // Requester identifiers, also used as the response owner tag.
    localparam logic CPU = 1'b0;
    localparam logic DBG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/reg_port_arbiter_rr_arb2.sv
// rr_arb2: two-requester grant logic. Round robin between cpu and dbg, or a
// fixed debug-wins priority when DBG_PRIORITY is non-zero. Grants are
// combinational; the fairness pointer advances only when a grant is taken.
module rr_arb2 #(
    parameter int DBG_PRIORITY = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_cpu_req,
    input  logic i_dbg_req,
    input  logic i_accept,
    output logic o_cpu_gnt,
    output logic o_dbg_gnt
);

    // 1 = dbg wins the next tie; cleared so the cpu is served first after reset.
    logic r_dbg_next;
    logic w_dbg_wins;

    // Grant decode: a lone requester always wins, a tie goes by mode/pointer.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        w_dbg_wins = i_dbg_req && (!i_cpu_req || (DBG_PRIORITY != 0) || r_dbg_next);
        o_dbg_gnt  = w_dbg_wins;
        o_cpu_gnt  = i_cpu_req && !w_dbg_wins;
    end

    // Fairness pointer: whoever was just served yields the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbg_next <= 1'b0;
        end else if (i_accept) begin
            // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
            r_dbg_next <= o_cpu_gnt;
        end
    end

endmodule

// File: rtl/reg_port_arbiter.sv
// reg_port_arbiter: shares a single register-file port between a CPU and a
// debug requester. One access is in flight at a time: accept in IDLE, one
// strobe cycle in ACCESS, then the response is held in RESP until its owner
// consumes it.
module reg_port_arbiter
    import reg_port_arbiter_pkg::*;
#(
    parameter int DBG_PRIORITY = 0
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cpu_req_valid,
    output logic             cpu_req_ready,
    input  logic             cpu_req_write,
    input  logic [SEL_W-1:0] cpu_req_sel,
    input  logic [REG_W-1:0] cpu_req_wdata,
    output logic             cpu_rsp_valid,
    input  logic             cpu_rsp_ready,

    input  logic             dbg_req_valid,
    output logic             dbg_req_ready,
    input  logic             dbg_req_write,
    input  logic [SEL_W-1:0] dbg_req_sel,
    input  logic [REG_W-1:0] dbg_req_wdata,
    output logic             dbg_rsp_valid,
    input  logic             dbg_rsp_ready,

    output logic [REG_W-1:0] rsp_data,

    output logic [SEL_W-1:0] rf_dst_sel,
    output logic [REG_W-1:0] rf_in,
    output logic             rf_in_en,
    output logic             rf_out_en,
    input  logic [REG_W-1:0] rf_out
);

    state_t             r_state;
    logic               r_owner;
    logic [REG_W-1:0]   r_rsp_data;
    logic [SEL_W-1:0]   r_rf_dst_sel;
    logic [REG_W-1:0]   r_rf_in;
    logic               r_rf_in_en;
    logic               r_rf_out_en;

    logic               w_cpu_gnt;
    logic               w_dbg_gnt;
    logic               w_idle;
    logic               w_resp;
    logic               w_accept;
    logic [SEL_W-1:0]   w_sel;
    logic [REG_W-1:0]   w_wdata;
    logic               w_write;
    logic               w_owner_rsp_ready;

    rr_arb2 #(
        .DBG_PRIORITY (DBG_PRIORITY)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_cpu_req (cpu_req_valid),
        .i_dbg_req (dbg_req_valid),
        .i_accept  (w_accept),
        .o_cpu_gnt (w_cpu_gnt),
        .o_dbg_gnt (w_dbg_gnt)
    );

    // Handshake decode: ready only in IDLE to the granted requester, response
    // valid only to the owner; both are suppressed while rst is asserted.
    always_comb begin
        w_idle            = (r_state == ST_IDLE) && !rst;
        w_resp            = (r_state == ST_RESP) && !rst;
        cpu_req_ready     = w_idle && w_cpu_gnt;
        dbg_req_ready     = w_idle && w_dbg_gnt;
        w_accept          = cpu_req_ready || dbg_req_ready;
        cpu_rsp_valid     = w_resp && (r_owner == CPU);
        dbg_rsp_valid     = w_resp && (r_owner == DBG);
        w_owner_rsp_ready = (r_owner == DBG) ? dbg_rsp_ready : cpu_rsp_ready;
        w_sel             = w_dbg_gnt ? dbg_req_sel   : cpu_req_sel;
        w_wdata           = w_dbg_gnt ? dbg_req_wdata : cpu_req_wdata;
        w_write           = w_dbg_gnt ? dbg_req_write : cpu_req_write;
    end

    // Access sequencer: latch the granted request, strobe the register file
    // for exactly one cycle, capture the read data and hold it for the owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: all sequencer registers are cleared, not just the state, so an aborted access leaves no stale strobe, select or data on the pins.
            r_state      <= ST_IDLE;
            r_owner      <= CPU;
            r_rsp_data   <= '0;
            r_rf_dst_sel <= '0;
            r_rf_in      <= '0;
            r_rf_in_en   <= 1'b0;
            r_rf_out_en  <= 1'b0;
        end else begin
            // NOTE: strobes default low here and a later assignment in the same block overrides it, which makes them one-cycle pulses.
            r_rf_in_en  <= 1'b0;
            r_rf_out_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_owner      <= w_dbg_gnt ? DBG : CPU;
                        r_rf_dst_sel <= w_sel;
                        r_rf_in      <= w_wdata;
                        r_rf_in_en   <= w_write;
                        r_rf_out_en  <= !w_write;
                        r_state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Write responses carry zero; reads take the port data now.
                    r_rsp_data <= r_rf_in_en ? '0 : rf_out;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_owner_rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_data   = r_rsp_data;
    assign rf_dst_sel = r_rf_dst_sel;
    assign rf_in      = r_rf_in;
    assign rf_in_en   = r_rf_in_en;
    assign rf_out_en  = r_rf_out_en;

endmodule
